// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
// ---------------------------------------------------------------------------
// Multi-cycle unsigned restoring divider. One trial subtraction per clock,
// done in the Diff/Borr form R + ~D + 1 over WIDTH+1 bits. Bit WIDTH of the
// trial result is the borrow. When the borrow is set the partial remainder is
// restored (kept as it was) and a 0 quotient bit is shifted in.
//
// Optional feature (macro SIGNED_DIV_EN): adds the signed_op input. When
// signed_op is set, the operands are divided as two's-complement values.
// The overflow case (most negative / -1) finishes without iterating.
//
// Handshake: start is sampled only in IDLE. The accepting edge latches the
// operands and raises busy. busy stays high for WIDTH cycles. done then
// pulses for one cycle, and the results become valid in that same cycle.
// The results hold until the next accepted start. A start seen while busy
// or in DONE is dropped, not queued. A divisor of 0 skips BUSY entirely.
//
// The FSM register is `state` (type state_t), open to hierarchical probes.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        division request
//   dividend     numerator, latched on the accepting edge
//   divisor      denominator, latched on the accepting edge
//   signed_op    (SIGNED_DIV_EN only) treat the operands as signed
//   quotient     registered quotient
//   remainder    registered remainder
//   busy         high while the iterations run
//   done         one-cycle completion pulse
//   div_by_zero  set with done when the divisor was 0; held with the results
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic             signed_op,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   ONE_W1   = (WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] part_quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    count;

  // One iteration. The shift moves the MSB of Q into R. R stays below
  // 2^(WIDTH-1) until the last shift, so WIDTH bits hold the shifted value.
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH-1:0] quo_shift;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_quo;
  logic [CW-1:0]    count_next;

  assign rem_shift  = {part_rem[WIDTH-2:0], part_quo[WIDTH-1]};
  assign quo_shift  = {part_quo[WIDTH-2:0], 1'b0};
  assign trial      = {1'b0, rem_shift} + {1'b1, ~dvs} + ONE_W1;
  assign borrow     = trial[WIDTH];
  assign next_rem   = borrow ? rem_shift : trial[WIDTH-1:0];
  assign next_quo   = {quo_shift[WIDTH-1:1], ~borrow};
  assign count_next = count + CW'(1);

  // Operand conditioning and result sign fix-up
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             ovf;
  logic [WIDTH-1:0] fin_quo;
  logic [WIDTH-1:0] fin_rem;

`ifdef SIGNED_DIV_EN
  logic neg_quo;
  logic neg_rem;
  logic a_neg;
  logic b_neg;

  assign a_neg   = signed_op & dividend[WIDTH-1];
  assign b_neg   = signed_op & divisor[WIDTH-1];
  // The magnitude of MOST_NEG is 2^(WIDTH-1), which is still exact when
  // read as unsigned.
  assign mag_a   = a_neg ? -dividend : dividend;
  assign mag_b   = b_neg ? -divisor  : divisor;
  assign ovf     = signed_op & (dividend == MOST_NEG) & (divisor == '1);
  assign fin_quo = neg_quo ? -next_quo : next_quo;
  assign fin_rem = neg_rem ? -next_rem : next_rem;
`else
  assign mag_a   = dividend;
  assign mag_b   = divisor;
  assign ovf     = 1'b0;
  assign fin_quo = next_quo;
  assign fin_rem = next_rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      part_rem    <= '0;
      part_quo    <= '0;
      dvs         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              // RV32I M convention: all-ones quotient, dividend as remainder
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= S_DONE;
            end else if (ovf) begin
              quotient    <= MOST_NEG;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              part_rem <= '0;
              part_quo <= mag_a;
              dvs      <= mag_b;
              count    <= '0;
              busy     <= 1'b1;
              state    <= S_BUSY;
`ifdef SIGNED_DIV_EN
              neg_quo  <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
`endif
            end
          end
        end
        S_BUSY: begin
          part_rem <= next_rem;
          part_quo <= next_quo;
          count    <= count_next;
          if (count_next == LAST) begin
            quotient    <= fin_quo;
            remainder   <= fin_rem;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider
// ---------------------------------------------------------------------------
// Directed bench for seq_restoring_divider at WIDTH=4. A transaction-level
// model computes each result with plain integer division. It tracks the
// cycle timing as "accept, then WIDTH busy cycles, then one done cycle",
// or "accept, then done" for divide by zero. A compare process checks the
// DUT against that model on every falling edge. Directed vectors pin the
// model with hand-computed literals.
// Valid/ready style: start is a request sampled only when the divider is
// idle; done is a one-cycle acknowledgement carrying the results.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         sop;

  int n_checks = 0;
  int n_err    = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SIGNED_DIV_EN
    .signed_op   (sop),
`endif
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         fast;  // finishes on the accept edge, without busy cycles
  } res_t;

  function automatic res_t model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic s);
    res_t res;
    int   ia;
    int   ib;
    logic [W-1:0] most_neg;
    most_neg = {1'b1, {(W-1){1'b0}}};
    res = '0;
    if (b == '0) begin
      res.q = '1; res.r = a; res.dz = 1'b1; res.fast = 1'b1;
    end else if (s && a == most_neg && b == '1) begin
      res.q = most_neg; res.r = '0; res.fast = 1'b1;
    end else if (s) begin
      ia = $signed(a);
      ib = $signed(b);
      res.q = W'(ia / ib);
      res.r = W'(ia % ib);
    end else begin
      res.q = a / b;
      res.r = a % b;
    end
    return res;
  endfunction

  res_t m_now;
  assign m_now = model_div(dividend, divisor, sop);

  int           m_phase;  // 0 idle, 1 iterating, 2 done cycle
  int           m_left;
  res_t         m_pend;
  logic [W-1:0] m_q;
  logic [W-1:0] m_r;
  logic         m_dz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_pend  <= '0;
      m_q     <= '0;
      m_r     <= '0;
      m_dz    <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          if (m_now.fast) begin
            m_phase <= 2;
            m_q     <= m_now.q;
            m_r     <= m_now.r;
            m_dz    <= m_now.dz;
          end else begin
            m_phase <= 1;
            m_left  <= W;
            m_pend  <= m_now;
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase <= 2;
            m_q     <= m_pend.q;
            m_r     <= m_pend.r;
            m_dz    <= 1'b0;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_busy", 32'(busy), 32'(m_phase == 1));
      chk("cyc_done", 32'(done), 32'(m_phase == 2));
      if (m_phase != 1) begin
        chk("cyc_quotient",  32'(quotient),    32'(m_q));
        chk("cyc_remainder", 32'(remainder),   32'(m_r));
        chk("cyc_dbz",       32'(div_by_zero), 32'(m_dz));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a falling edge. Returns on the falling edge where done is seen,
  // or after the bound. n counts falling edges, starting at 1 for the
  // current one.
  task automatic wait_done(output int n, output int nb);
    n  = 1;
    nb = 0;
    while (n < 40) begin
      if (done) break;
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input int elat, input int ebusy,
                        input string name);
    int n;
    int nb;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);  // first falling edge after the accepting edge
    start    = 1'b0;
    dividend = W'($urandom_range(0, (1 << W) - 1));
    divisor  = W'($urandom_range(0, (1 << W) - 1));
    wait_done(n, nb);
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    chk({name, "_latency"},   32'(n),    32'(elat));
    chk({name, "_busy_cyc"},  32'(nb),   32'(ebusy));
    chk({name, "_quotient"},  32'(quotient),    32'(eq));
    chk({name, "_remainder"}, 32'(remainder),   32'(er));
    chk({name, "_dbz"},       32'(div_by_zero), 32'(edz));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int nb;
    int cnt;
    rst_n    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    sop      = 1'b0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_quotient",  32'(quotient),    32'd0);
    chk("rst_remainder", 32'(remainder),   32'd0);
    chk("rst_busy",      32'(busy),        32'd0);
    chk("rst_done",      32'(done),        32'd0);
    chk("rst_dbz",       32'(div_by_zero), 32'd0);
    #2 rst_n = 1'b1;

    do_div(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, W + 1, W, "d13_3");
    do_div(4'd7,  4'd0, 4'd15, 4'd7, 1'b1, 1,     0, "d7_0");
    do_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, W + 1, W, "d15_1");

    // 2/5, with a 9/2 request pulsed mid-division that must be dropped
    @(negedge clk);
    dividend = 4'd2; divisor = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 4'd9; divisor = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, nb);
    chk("ign_done_seen", 32'(done),      32'd1);
    chk("ign_quotient",  32'(quotient),  32'd0);
    chk("ign_remainder", 32'(remainder), 32'd2);
    repeat (6) @(negedge clk);
    chk("ign_no_queue_busy", 32'(busy),      32'd0);
    chk("ign_hold_rem",      32'(remainder), 32'd2);

    // 14/3 aborted by reset in its second busy cycle
    @(negedge clk);
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_quotient",  32'(quotient),    32'd0);
    chk("abort_remainder", 32'(remainder),   32'd0);
    chk("abort_busy",      32'(busy),        32'd0);
    chk("abort_done",      32'(done),        32'd0);
    chk("abort_dbz",       32'(div_by_zero), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    do_div(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, W + 1, W, "d14_3");

    // start held high across 10/4 and then 8/2
    @(negedge clk);
    dividend = 4'd10; divisor = 4'd4; start = 1'b1;
    @(negedge clk);
    wait_done(n, nb);
    chk("held1_done_seen", 32'(done),      32'd1);
    chk("held1_quotient",  32'(quotient),  32'd2);
    chk("held1_remainder", 32'(remainder), 32'd2);
    dividend = 4'd8; divisor = 4'd2;
    @(negedge clk);
    chk("held_idle_gap_busy", 32'(busy), 32'd0);
    wait_done(n, nb);
    start = 1'b0;
    chk("held2_done_seen", 32'(done),      32'd1);
    chk("held2_gap",       32'(n),         32'(W + 2));
    chk("held2_quotient",  32'(quotient),  32'd4);
    chk("held2_remainder", 32'(remainder), 32'd0);

    // more unsigned boundaries
    do_div(4'd15, 4'd15, 4'd1,  4'd0, 1'b0, W + 1, W, "d15_15");
    do_div(4'd0,  4'd7,  4'd0,  4'd0, 1'b0, W + 1, W, "d0_7");
    do_div(4'd15, 4'd9,  4'd1,  4'd6, 1'b0, W + 1, W, "d15_9");
    do_div(4'd9,  4'd2,  4'd4,  4'd1, 1'b0, W + 1, W, "d9_2");
    do_div(4'd0,  4'd0,  4'd15, 4'd0, 1'b1, 1,     0, "d0_0");

`ifdef SIGNED_DIV_EN
    sop = 1'b1;
    do_div(4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, W + 1, W, "s_m7_2");
    do_div(4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1,     0, "s_ovf");
    do_div(4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, W + 1, W, "s_7_m2");
    do_div(4'b1010, 4'b0000, 4'b1111, 4'b1010, 1'b1, 1,     0, "s_m6_0");
    sop = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned integer divider. Each iteration performs one two's-complement trial subtraction (partial remainder + ~divisor + 1) and uses the borrow to decide whether to restore.
- Sits directly downstream of the team's combinational subtractor and consumes its Diff/Borr form, one trial subtraction per clock.
- Serves as the divide datapath for the RV32I course core's M-extension experiments. Start/busy/done handshake to the issuing logic.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator; latched on accepted start
- divisor  input  WIDTH  denominator; latched on accepted start
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, iteration counter=0, internal registers=0. Outputs quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
- Reset asserted mid-division aborts it; no done is produced.
- States:
  - IDLE: start=1 at edge E0 latches the operands.
    - divisor!=0: go to BUSY. Partial remainder R=0, Q=dividend, count=0, busy=1.
    - divisor==0: go to DONE. quotient=all ones, remainder=dividend, div_by_zero=1, busy=0.
  - BUSY, once per edge:
    - Shift {R,Q} left 1 (MSB of Q enters R).
    - Compute T = {1'b0,R} + {1'b1,~divisor} + 1 in WIDTH+1 bits.
    - T[WIDTH]=0 (no borrow): R=T[WIDTH-1:0], Q[0]=1.
    - Otherwise: R unchanged (restore), Q[0]=0.
    - count increments. On the edge where count reaches WIDTH: registers quotient=Q and remainder=R, div_by_zero=0, busy=0, state=DONE.
  - DONE: done=1 for exactly this one cycle, then IDLE unconditionally. Results and div_by_zero hold until the next accepted start.
- Latency: done is high in the cycle after edge E0+WIDTH (normal case) or edge E0+1 (divide by zero).
- busy: high for exactly WIDTH cycles (normal case); never high for divide by zero.
- Handshake: start while busy=1 or in DONE is ignored and not queued. start held high continuously begins a new division on the first IDLE cycle after DONE.
- Operand inputs may change freely after the accepting edge.
- Widths: trial subtraction is WIDTH+1 bits; the borrow is bit WIDTH; no overflow is possible for unsigned operands.
- The divide-by-zero result follows RV32I M convention (quotient all ones, remainder = dividend).

Optional Feature:
- Macro SIGNED_DIV_EN.
- Defined:
  - Adds input port signed_op (1 bit), latched with start.
  - If signed_op=1: operands are converted to magnitudes at latch. At the final iteration, quotient is negated when the operand signs differ, and remainder takes the dividend's sign.
  - Overflow case (dividend = most negative, divisor = all ones): result is quotient = most negative, remainder = 0, delivered via the DONE path one edge after accept.
  - Signed divide by zero: quotient = all ones, remainder = dividend.
  - Latency is otherwise unchanged.
- Undefined: no signed_op port; the block is unsigned only.

Test Plan:
- WIDTH=4, start with 13/3 -> busy high 4 cycles; done in 5th cycle after accept edge; quotient=4, remainder=1, div_by_zero=0.
- 7/0 -> no busy; done one cycle after accept; quotient=15, remainder=7, div_by_zero=1. Then 15/1 -> quotient=15, remainder=0, div_by_zero cleared.
- 2/5 -> quotient=0, remainder=2. start pulsed again during busy with 9/2 -> ignored; the original result is unchanged.
- Start 14/3, drop rst_n for 1 cycle at 2nd busy cycle -> all outputs 0 immediately, no done. Then 14/3 again -> quotient=4, remainder=2.
- start held high across two divisions 10/4 then 8/2 -> done pulses twice. Results 2 r2, then 4 r0; exactly one IDLE cycle between.
- SIGNED_DIV_EN, signed_op=1: -7/2 (1001/0010) -> quotient=1101, remainder=1111. -8/-1 -> quotient=1000, remainder=0000, done one cycle after accept.
